// File: rtl/switch_debounce_pkg.sv
// Shared constants and filter state encoding for the switch input conditioner.
package switch_debounce_pkg;

  localparam int unsigned SW_WIDTH     = 8;
  localparam int unsigned SW_DB_CYCLES = 16;
  localparam int unsigned SW_CNT_W     = 5;

  typedef enum logic {
    STABLE  = 1'b0,
    PENDING = 1'b1
  } db_state_e;

endpackage

// File: rtl/db_bit_filter.sv
// One switch bit: two-flop synchronizer, debounce counter and STABLE/PENDING filter.
module db_bit_filter
  import switch_debounce_pkg::*;
#(
  parameter int unsigned DB_CYCLES = SW_DB_CYCLES,
  parameter int unsigned CNT_W     = SW_CNT_W,
  parameter logic        RST_VAL   = 1'b0
) (
  input  logic iClk,
  input  logic iRst_n,
  input  logic iRaw,
  output logic oDb,
  output logic oAccept
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DB_CYCLES - 1);

  logic             s1_q, s2_q;
  logic             db_q, db_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  db_state_e        state_q, state_d;
  logic             mismatch;
  logic             accept;

  assign mismatch = (s2_q != db_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    db_d    = db_q;
    accept  = 1'b0;
    unique case (state_q)
      STABLE: begin
        if (mismatch) begin
          if (DB_CYCLES == 1) begin
            accept = 1'b1;
          end else begin
            cnt_d   = CNT_W'(1);
            state_d = PENDING;
          end
        end
      end
      PENDING: begin
        if (!mismatch) begin
          // Glitch: drop it and restart the full count on the next mismatch.
          cnt_d   = '0;
          state_d = STABLE;
        end else if (cnt_q == CntMax) begin
          accept = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = STABLE;
      end
    endcase
    if (accept) begin
      db_d    = s2_q;
      cnt_d   = '0;
      state_d = STABLE;
    end
  end

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      s1_q    <= RST_VAL;
      s2_q    <= RST_VAL;
      db_q    <= RST_VAL;
      cnt_q   <= '0;
      state_q <= STABLE;
    end else begin
      s1_q    <= iRaw;
      s2_q    <= s1_q;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  assign oDb = db_q;
  // Combinational: high in the cycle whose closing edge updates oDb.
  assign oAccept = accept;

endmodule

// File: rtl/switch_debounce.sv
// Debounced switch word for the CPU with sticky per-bit change flags and a summary IRQ.
module switch_debounce
  import switch_debounce_pkg::*;
#(
  parameter int unsigned      WIDTH     = SW_WIDTH,
  parameter int unsigned      DB_CYCLES = SW_DB_CYCLES,
  parameter int unsigned      CNT_W     = SW_CNT_W,
  parameter logic [WIDTH-1:0] RST_VAL   = '0
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic [WIDTH-1:0] iSwitchRaw,
  input  logic             iClr,
  output logic [WIDTH-1:0] oSwitch,
  output logic [WIDTH-1:0] oChanged,
  output logic             oIrq
);

  logic [WIDTH-1:0] accept;
  logic [WIDTH-1:0] changed_q, changed_d;
  logic             irq_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    db_bit_filter #(
      .DB_CYCLES(DB_CYCLES),
      .CNT_W    (CNT_W),
      .RST_VAL  (RST_VAL[i])
    ) u_filter (
      .iClk   (iClk),
      .iRst_n (iRst_n),
      .iRaw   (iSwitchRaw[i]),
      .oDb    (oSwitch[i]),
      .oAccept(accept[i])
    );
  end

  // Accepts win over a simultaneous clear so no event is lost.
  always_comb begin
    changed_d = iClr ? '0 : changed_q;
    changed_d = changed_d | accept;
  end

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      changed_q <= '0;
      irq_q     <= 1'b0;
    end else begin
      changed_q <= changed_d;
      irq_q     <= |changed_d;
    end
  end

  assign oChanged = changed_q;
  assign oIrq     = irq_q;

endmodule

// File: tb/tb_switch_debounce.sv
// Scoreboard bench: stimulus queues cycle-stamped expectations, a negedge monitor checks them.
module tb_switch_debounce;

  logic       clk;
  logic       rst_n;
  logic [7:0] raw;
  logic       clr;
  logic [7:0] sw;
  logic [7:0] chg;
  logic       irq;

  switch_debounce dut (
    .iClk      (clk),
    .iRst_n    (rst_n),
    .iSwitchRaw(raw),
    .iClr      (clr),
    .oSwitch   (sw),
    .oChanged  (chg),
    .oIrq      (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         at;
    int         kind;  // 0: port state, 1: bit7 toggle count
    logic [7:0] sw;
    logic [7:0] ch;
    logic       irq;
    int         cnt;
    string      name;
  } exp_t;

  exp_t sb_q[$];
  exp_t e;
  int   errors = 0;
  int   checks = 0;
  bit   done = 0;
  bit   drained = 0;
  bit   win7 = 0;
  int   count7 = 0;
  logic prev7;
  bit   ok;

  task automatic push_state(input int at, input logic [7:0] s, input logic [7:0] c,
                            input logic i, input string name);
    exp_t x;
    x.at = at; x.kind = 0; x.sw = s; x.ch = c; x.irq = i; x.cnt = 0; x.name = name;
    sb_q.push_back(x);
  endtask

  task automatic push_count(input int at, input int n, input string name);
    exp_t x;
    x.at = at; x.kind = 1; x.sw = '0; x.ch = '0; x.irq = 1'b0; x.cnt = n; x.name = name;
    sb_q.push_back(x);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Monitor: counts bit7 transitions of oSwitch and checks every expectation due this cycle.
  always @(negedge clk) begin
    if (!win7) count7 = 0;
    else if (sw[7] !== prev7) count7++;
    prev7 = sw[7];
    while (sb_q.size() > 0 && (done || sb_q[0].at <= cyc)) begin
      e = sb_q.pop_front();
      checks++;
      if (e.kind == 0) begin
        ok = (e.at == cyc) && (sw === e.sw) && (chg === e.ch) && (irq === e.irq);
        if (!ok) begin
          errors++;
          $display("FAIL %s cyc=%0d (due %0d): got sw=%h chg=%h irq=%b, expected sw=%h chg=%h irq=%b",
                   e.name, cyc, e.at, sw, chg, irq, e.sw, e.ch, e.irq);
        end
      end else begin
        ok = (e.at == cyc) && (count7 == e.cnt);
        if (!ok) begin
          errors++;
          $display("FAIL %s cyc=%0d (due %0d): got count=%0d, expected count=%0d",
                   e.name, cyc, e.at, count7, e.cnt);
        end
      end
    end
    if (done) drained = 1;
  end

  int c;
  int r;

  initial begin
    // 1: reset with raw=fc, release and hold
    rst_n = 1'b0; raw = 8'hfc; clr = 1'b0;
    step(3);
    c = cyc;
    push_state(c, 8'h00, 8'h00, 1'b0, "reset_state");
    rst_n = 1'b1;
    push_state(c + 17, 8'h00, 8'h00, 1'b0, "t1_edge17");
    push_state(c + 18, 8'hfc, 8'hfc, 1'b1, "t1_edge18");
    step(18);

    // 2: 10-cycle glitch on bit0 is rejected
    c = cyc;
    raw = 8'hfd;
    push_state(c + 5, 8'hfc, 8'hfc, 1'b1, "t2_glitch_mid");
    step(10);
    raw = 8'hfc;
    push_state(c + 18, 8'hfc, 8'hfc, 1'b1, "t2_glitch_e18");
    push_state(c + 25, 8'hfc, 8'hfc, 1'b1, "t2_glitch_after");
    step(15);

    // 3: single clear pulse
    c = cyc;
    clr = 1'b1;
    push_state(c + 1, 8'hfc, 8'h00, 1'b0, "t3_clear");
    step(1);
    clr = 1'b0;
    step(2);

    // 4: clear coincides with bit1 accept
    c = cyc;
    raw = 8'hfe;
    push_state(c + 17, 8'hfc, 8'h00, 1'b0, "t4_pre_accept");
    push_state(c + 18, 8'hfe, 8'h02, 1'b1, "t4_clr_and_accept");
    push_state(c + 19, 8'hfe, 8'h02, 1'b1, "t4_hold");
    step(17);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    step(2);

    // 5: reset at the 8th PENDING edge abandons the count
    c = cyc;
    raw = 8'h01;
    push_state(c + 9, 8'hfe, 8'h02, 1'b1, "t5_pending");
    push_state(c + 10, 8'h00, 8'h00, 1'b0, "t5_reset");
    step(9);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    r = cyc;
    push_state(r + 17, 8'h00, 8'h00, 1'b0, "t5_edge17");
    push_state(r + 18, 8'h01, 8'h01, 1'b1, "t5_edge18");
    step(18);

    // 6: bit7 bounces every 3 cycles, then settles high
    clr = 1'b1;
    push_state(cyc + 1, 8'h01, 8'h00, 1'b0, "t6_clear");
    step(1);
    clr = 1'b0;
    c = cyc;
    win7 = 1'b1;
    push_state(c + 15, 8'h01, 8'h00, 1'b0, "t6_bounce_mid");
    push_state(c + 29, 8'h01, 8'h00, 1'b0, "t6_bounce_end");
    for (int k = 0; k < 10; k++) begin
      raw = (k % 2 == 0) ? 8'h81 : 8'h01;
      step(3);
    end
    raw = 8'h81;
    r = cyc;
    push_state(r + 17, 8'h01, 8'h00, 1'b0, "t6_edge17");
    push_state(r + 18, 8'h81, 8'h80, 1'b1, "t6_edge18");
    push_count(r + 20, 1, "t6_bit7_accepts");
    step(22);

    done = 1'b1;
    for (int i = 0; i < 20 && !drained; i++) @(posedge clk);
    if (!drained) begin
      $display("FAIL monitor_drain: got drained=0, expected drained=1");
      $fatal(1, "monitor did not drain");
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/switch_debounce.md
Name: switch_debounce

Overview:
Input conditioner that sits directly upstream of the single-cycle CPU's 8-bit switch port.
- Synchronizes the raw board switches into iClk.
- Debounces each bit independently.
- Presents a stable switch word to the CPU.
- Latches per-bit change events, with a read-clear handshake and an interrupt-style summary flag.

Parameters:
WIDTH, 8, number of switch bits.
DB_CYCLES, 16, consecutive cycles a synchronized bit must differ from its debounced value before it is accepted (legal range is 1 or more).
CNT_W, 5, debounce counter width; must satisfy 2**CNT_W > DB_CYCLES-1.
RST_VAL, 8'h00, value of oSwitch after reset.

Ports:
iClk  input  1  system clock; all state updates on the rising edge.
iRst_n  input  1  reset: synchronous, active-low.
iSwitchRaw  input  WIDTH  asynchronous raw switch levels from the pads.
iClr  input  1  single-cycle pulse from the CPU; clears all change flags.
oSwitch  output  WIDTH  debounced switch word; drives the CPU's iSwitch.
oChanged  output  WIDTH  sticky per-bit "debounced value changed" flags.
oIrq  output  1  OR-reduction of oChanged, registered.

Behaviour:
- Reset: when iRst_n is low at a rising edge, the following take effect at that edge:
  - Both synchronizer stages are set to RST_VAL.
  - oSwitch is set to RST_VAL.
  - All counters are set to 0.
  - oChanged is set to 0 and oIrq to 0.
  - Reset overrides every other input, including iClr.
- Synchronizer: two flops per bit, s1 <= iSwitchRaw and s2 <= s1. No logic sits between s1 and s2.
- Per-bit filter: two states, STABLE and PENDING.
  - STABLE (cnt=0):
    - s2[i]==oSwitch[i]: stay in STABLE.
    - Otherwise: cnt <= 1 and go to PENDING. If DB_CYCLES==1, accept immediately instead (see "Accept").
  - PENDING:
    - s2[i]==oSwitch[i]: cnt <= 0 and return to STABLE. The glitch is discarded.
    - Mismatch with cnt==DB_CYCLES-1: accept.
    - Other mismatches: cnt <= cnt+1.
  - Accept: oSwitch[i] <= s2[i], cnt <= 0, state <= STABLE, oChanged[i] <= 1.
- Counter never wraps; its maximum value is DB_CYCLES-1.
- Latency: call the first edge that samples a new raw level edge 1. oSwitch reflects the new level after edge DB_CYCLES+2 (edge 18 by default), provided the raw level is held through edge DB_CYCLES+1.
- Any return to the old level during PENDING restarts the full count.
- Bits are fully independent. Several bits may accept on the same edge; each sets its own flag.
- oChanged:
  - Set by accept, cleared by iClr.
  - If iClr and an accept occur on the same edge, the accepting bits end at 1 and all others at 0. Events are never lost.
  - iClr held for multiple cycles behaves as repeated clears.
- oIrq <= |(next oChanged), so it tracks oChanged with no extra cycle of delay.
- Reset mid-PENDING: the count is abandoned. After release, a raw level different from RST_VAL requires the full DB_CYCLES+2 edges again.

Decomposition:
- Shared package holds:
  - Default constants: SW_WIDTH=8, SW_DB_CYCLES=16, SW_CNT_W=5.
  - A one-bit filter state enum with values STABLE and PENDING.
- One natural sub-module: db_bit_filter. It contains one bit's synchronizer, counter and state, and outputs the debounced bit plus a one-cycle accept pulse.
- switch_debounce instantiates WIDTH copies of db_bit_filter and owns oChanged and oIrq.

Test Plan:
1. Reset with raw=8'hfc, then release and hold 8'hfc. Required: oSwitch=8'h00 through edge 17 after release, and 8'hfc after edge 18. oChanged=8'hfc, oIrq=1.
2. From a stable 8'hfc, drive bit0 high for 10 cycles, then low. Required: oSwitch stays 8'hfc and oChanged is unchanged.
3. Pulse iClr for one cycle. Required: oChanged=8'h00 and oIrq=0 after that edge; oSwitch is unaffected.
4. Change bit1 to 1 and time iClr to coincide with its accept edge. Required: oChanged=8'h02 and oIrq=1 afterwards.
5. Change raw to 8'h01, then assert iRst_n low at the 8th edge of PENDING for 1 cycle. Required:
   - oSwitch=8'h00 and oChanged=8'h00 immediately.
   - After release with raw still 8'h01, oSwitch=8'h01 only after 18 further edges.
6. Toggle bit7 every 3 cycles for 30 cycles, then hold it at 1. Required:
   - Exactly one accept on bit7, 18 edges after its final transition is first sampled.
   - oChanged[7] rises once.
